// File: rtl/pattern_judge.sv
// rtl/pattern_judge.sv - LED reaction game round controller: requests, shows and judges patterns.
// Optional PATTERN_JUDGE_SPEEDUP_EN shortens the per-round timeout as the score grows.
module pattern_judge #(
  parameter int WIDTH      = 18,
  parameter int SCORE_W    = 8,
  parameter int LIVES      = 3,
  parameter int TIMEOUT    = 50_000_000,
  parameter int SAMPLE_DLY = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               play,
  input  logic [WIDTH-1:0]   sw_in,
  input  logic [WIDTH-1:0]   gen_pat,
  output logic               gen_start,
  output logic [WIDTH-1:0]   led_out,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic               round_hit,
  output logic               round_miss,
  output logic               busy,
  output logic               game_over
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int DW = (SAMPLE_DLY > 1) ? $clog2(SAMPLE_DLY) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_REQ, S_SHOW, S_HIT, S_MISS, S_OVER
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sw_meta_q, sw_sync_q;
  logic [WIDTH-1:0]   target_q, target_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [DW-1:0]      req_cnt_q, req_cnt_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [1:0]         lives_q, lives_d;
  logic               gen_start_d, hit_d, miss_d, busy_d, over_d;
  logic [WIDTH-1:0]   led_d;
  logic               timeout_hit;

`ifdef PATTERN_JUDGE_SPEEDUP_EN
  // Every 4 hits trims TIMEOUT/8, capped at 4 steps; latched on SHOW entry so a round never changes mid-way.
  logic [TW-1:0]      limit_q, limit_new;
  logic [SCORE_W-1:0] quads;
  logic [2:0]         steps;
  logic               enter_show;

  always_comb begin
    quads      = score_q >> 2;
    steps      = (quads > SCORE_W'(4)) ? 3'd4 : quads[2:0];
    limit_new  = TW'(TIMEOUT) - TW'(TIMEOUT >> 3) * TW'(steps);
    enter_show = (state_q == S_REQ) && (state_d == S_SHOW);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        limit_q <= TW'(TIMEOUT);
    else if (enter_show) limit_q <= limit_new;
  end

  assign timeout_hit = (timer_q == limit_q - TW'(1));
`else
  assign timeout_hit = (timer_q == TW'(TIMEOUT - 1));
`endif

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    timer_d   = timer_q;
    req_cnt_d = req_cnt_q;
    score_d   = score_q;
    lives_d   = lives_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (play) begin
          score_d = '0;
          lives_d = 2'(LIVES);
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (sw_sync_q == '0) begin
          req_cnt_d = '0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (req_cnt_q == DW'(SAMPLE_DLY - 1)) begin
          target_d = gen_pat;
          timer_d  = '0;
          state_d  = (gen_pat == '0) ? S_CLEAR : S_SHOW;
        end else begin
          req_cnt_d = req_cnt_q + 1'b1;
        end
      end
      S_SHOW: begin
        // Wrong switch beats a match; a match on the last timeout cycle still counts.
        if ((sw_sync_q & ~target_q) != '0) begin
          lives_d = lives_q - 1'b1;
          state_d = S_MISS;
        end else if (sw_sync_q == target_q) begin
          score_d = (&score_q) ? score_q : score_q + 1'b1;
          state_d = S_HIT;
        end else if (timeout_hit) begin
          lives_d = lives_q - 1'b1;
          state_d = S_MISS;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_HIT:   state_d = S_CLEAR;
      S_MISS:  state_d = (lives_q == 2'd0) ? S_OVER : S_CLEAR;
      default: state_d = S_IDLE;
    endcase

    gen_start_d = (state_d == S_REQ);
    led_d       = (state_d == S_SHOW) ? target_d : '0;
    hit_d       = (state_d == S_HIT);
    miss_d      = (state_d == S_MISS);
    busy_d      = (state_d != S_IDLE) && (state_d != S_OVER);
    over_d      = (state_d == S_OVER);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      target_q   <= '0;
      timer_q    <= '0;
      req_cnt_q  <= '0;
      score_q    <= '0;
      lives_q    <= 2'(LIVES);
      gen_start  <= 1'b0;
      led_out    <= '0;
      round_hit  <= 1'b0;
      round_miss <= 1'b0;
      busy       <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sw_meta_q  <= sw_in;
      sw_sync_q  <= sw_meta_q;
      target_q   <= target_d;
      timer_q    <= timer_d;
      req_cnt_q  <= req_cnt_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      gen_start  <= gen_start_d;
      led_out    <= led_d;
      round_hit  <= hit_d;
      round_miss <= miss_d;
      busy       <= busy_d;
      game_over  <= over_d;
    end
  end

  assign score = score_q;
  assign lives = lives_q;

endmodule

// File: tb/tb_pattern_judge.sv
// tb/tb_pattern_judge.sv - directed self-checking bench for pattern_judge.
module tb_pattern_judge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        play;
  logic [17:0] sw_in;
  logic [17:0] gen_pat;
  logic        gen_start;
  logic [17:0] led_out;
  logic [7:0]  score;
  logic [1:0]  lives;
  logic        round_hit, round_miss, busy, game_over;

  int checks   = 0;
  int failures = 0;

  pattern_judge #(
    .WIDTH(18), .SCORE_W(8), .LIVES(3), .TIMEOUT(16), .SAMPLE_DLY(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .play(play), .sw_in(sw_in), .gen_pat(gen_pat),
    .gen_start(gen_start), .led_out(led_out), .score(score), .lives(lives),
    .round_hit(round_hit), .round_miss(round_miss), .busy(busy), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Steps until LEDs light (bounded), then checks the shown pattern.
  task automatic wait_show(input string tag, input logic [17:0] exp_t);
    int n;
    n = 0;
    while (led_out == 18'h0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(led_out), 32'(exp_t));
  endtask

  // Counts SHOW cycles from the first SHOW cycle until LEDs change.
  task automatic show_len(input logic [17:0] tgt, output int n);
    n = 0;
    while (led_out == tgt && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0;
    play    = 1'b0;
    sw_in   = 18'h0;
    gen_pat = 18'h0;
    step(2);
    chk("rst_gen_start", 32'(gen_start), 32'h0);
    chk("rst_led", 32'(led_out), 32'h0);
    chk("rst_score", 32'(score), 32'h0);
    chk("rst_lives", 32'(lives), 32'h3);
    chk("rst_pulses", 32'({round_hit, round_miss}), 32'h0);
    chk("rst_busy_over", 32'({busy, game_over}), 32'h0);
    reset_n = 1'b1;

    // Round 1: hit with exact cycle timing
    gen_pat = 18'h15A20;
    play    = 1'b1;
    step(1);
    play = 1'b0;
    chk("r1_clear_busy", 32'(busy), 32'h1);
    chk("r1_clear_gs", 32'(gen_start), 32'h0);
    step(1);
    chk("r1_req_gs0", 32'(gen_start), 32'h1);
    step(1);
    chk("r1_req_gs1", 32'(gen_start), 32'h1);
    step(1);
    chk("r1_show_gs", 32'(gen_start), 32'h0);
    chk("r1_show_led", 32'(led_out), 32'h15A20);
    sw_in = 18'h15A20;
    step(2);
    chk("r1_no_early_hit", 32'(round_hit), 32'h0);
    step(1);
    chk("r1_hit", 32'(round_hit), 32'h1);
    chk("r1_score", 32'(score), 32'h1);
    chk("r1_lives", 32'(lives), 32'h3);
    step(1);
    chk("r1_hit_once", 32'(round_hit), 32'h0);
    chk("r1_clear_led", 32'(led_out), 32'h0);
    step(3);
    chk("r1_wait_sw0", 32'({busy, gen_start}), 32'h2);

    // Round 2: switch outside target
    gen_pat = 18'h12126;
    sw_in   = 18'h0;
    wait_show("r2_show_led", 18'h12126);
    sw_in = 18'h00001;
    step(2);
    chk("r2_no_early_miss", 32'(round_miss), 32'h0);
    step(1);
    chk("r2_miss", 32'(round_miss), 32'h1);
    chk("r2_lives", 32'(lives), 32'h2);
    chk("r2_score", 32'(score), 32'h1);

    // Round 3: timeout with switches at zero
    sw_in   = 18'h0;
    gen_pat = 18'h06A44;
    wait_show("r3_show_led", 18'h06A44);
    show_len(18'h06A44, n);
    chk("r3_show_len", 32'(n), 32'd16);
    chk("r3_miss", 32'(round_miss), 32'h1);
    chk("r3_lives", 32'(lives), 32'h1);

    // Round 4: zero pattern forces a retry
    gen_pat = 18'h0;
    n = 0;
    while (gen_start == 1'b0 && n < 20) begin step(1); n++; end
    chk("r4_req1_seen", 32'(gen_start), 32'h1);
    n = 0;
    while (gen_start == 1'b1 && n < 20) begin step(1); n++; end
    chk("r4_req1_len", 32'(n), 32'd2);
    chk("r4_no_show", 32'(led_out), 32'h0);
    gen_pat = 18'h0003F;
    n = 0;
    while (gen_start == 1'b0 && n < 20) begin step(1); n++; end
    chk("r4_low_gap", 32'(n >= 1 && n < 20), 32'h1);
    n = 0;
    while (gen_start == 1'b1 && n < 20) begin step(1); n++; end
    chk("r4_req2_len", 32'(n), 32'd2);
    chk("r4_show_led", 32'(led_out), 32'h0003F);
    play = 1'b1;
    step(1);
    play = 1'b0;
    chk("r4_play_ignored", 32'({busy, led_out}), 32'({1'b1, 18'h0003F}));
    chk("r4_score_kept", 32'(score), 32'h1);
    sw_in = 18'h20000;
    step(3);
    chk("r4_miss", 32'(round_miss), 32'h1);
    chk("r4_lives0", 32'(lives), 32'h0);
    step(1);
    chk("over_flag", 32'(game_over), 32'h1);
    chk("over_busy", 32'(busy), 32'h0);
    chk("over_led", 32'(led_out), 32'h0);
    chk("over_score", 32'(score), 32'h1);
    sw_in = 18'h0;
    step(3);
    chk("over_holds", 32'({game_over, lives}), 32'h4);
    play = 1'b1;
    step(1);
    play = 1'b0;
    chk("replay_score", 32'(score), 32'h0);
    chk("replay_lives", 32'(lives), 32'h3);
    chk("replay_state", 32'({busy, game_over}), 32'h2);

    // Asynchronous reset while in SHOW
    wait_show("rst_show_led", 18'h0003F);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_led", 32'(led_out), 32'h0);
    chk("arst_gs_busy", 32'({gen_start, busy, game_over}), 32'h0);
    chk("arst_score_lives", 32'({score, lives}), 32'h3);
    step(1);
    reset_n = 1'b1;
    step(1);
    chk("post_rst_idle", 32'(busy), 32'h0);

`ifdef PATTERN_JUDGE_SPEEDUP_EN
    play = 1'b1;
    step(1);
    play = 1'b0;
    gen_pat = 18'h00F0F;
    for (int r = 0; r < 8; r++) begin
      sw_in = 18'h0;
      wait_show("sp_show", 18'h00F0F);
      sw_in = 18'h00F0F;
      n = 0;
      while (round_hit == 1'b0 && n < 20) begin step(1); n++; end
      chk("sp_hit", 32'(round_hit), 32'h1);
    end
    chk("sp_score8", 32'(score), 32'd8);
    sw_in = 18'h0;
    wait_show("sp_show_t", 18'h00F0F);
    show_len(18'h00F0F, n);
    chk("sp_show_len", 32'(n), 32'd12);
    chk("sp_miss", 32'(round_miss), 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
